// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path).
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;
   localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: one shift-add multiply or restoring divide step per step_i.
// Operates on magnitudes only; sign handling lives in the sequencer.
module muldiv_core
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_nxt_o,
   output logic [WIDTH-1:0] lo_nxt_o
);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             div_q, div_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   // hi:lo is the product (multiply) or remainder:quotient (divide) pair.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_diff  = div_shift[WIDTH-1:0] - b_q;
      if (div_q) begin
         hi_nxt_o = div_ge ? div_diff : div_shift[WIDTH-1:0];
         lo_nxt_o = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         hi_nxt_o = mul_sum[WIDTH:1];
         lo_nxt_o = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      b_d   = b_q;
      div_d = div_q;
      if (load_i) begin
         hi_d  = '0;
         lo_d  = a_i;
         b_d   = b_i;
         div_d = div_i;
      end else if (step_i) begin
         hi_d = hi_nxt_o;
         lo_d = lo_nxt_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: FSM, counter, sign handling, early-out and stall.
// Optional feature macro: MULDIV_FAST_MUL_EN (multiplies complete in one cycle).
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             result_valid_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   muldiv_op_e       op_q, op_d;
   logic             neg_res_q, neg_res_d;
   logic [WIDTH-1:0] result_q, result_d;

   muldiv_op_e       op_in;
   logic             accept;
   logic             a_sgn, b_sgn, a_neg, b_neg, res_neg;
   logic             div_zero, div_ovf;
   logic [WIDTH-1:0] a_mag, b_mag, early_res;
   logic             core_load, core_step;
   logic [WIDTH-1:0] hi_nxt, lo_nxt;
   logic [2*WIDTH-1:0] prod_mag, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix, final_res;

   // Operands are reduced to magnitudes at latch time; only the result sign is kept.
   always_comb begin
      op_in     = muldiv_op_e'(op_i);
      accept    = start_i & ~flush_i;
      a_sgn     = (op_in == OP_MULH) | (op_in == OP_MULHSU) | (op_in == OP_DIV) | (op_in == OP_REM);
      b_sgn     = (op_in == OP_MULH) | (op_in == OP_DIV) | (op_in == OP_REM);
      a_neg     = a_sgn & a_i[WIDTH-1];
      b_neg     = b_sgn & b_i[WIDTH-1];
      a_mag     = a_neg ? -a_i : a_i;
      b_mag     = b_neg ? -b_i : b_i;
      res_neg   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
      div_zero  = op_i[2] & (b_i == '0);
      div_ovf   = op_i[2] & ~op_i[0] & (a_i == MOST_NEG) & (b_i == '1);
      early_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
   logic [WIDTH-1:0]   fast_res;

   always_comb begin
      fast_a    = {{WIDTH{a_sgn & a_i[WIDTH-1]}}, a_i};
      fast_b    = {{WIDTH{b_sgn & b_i[WIDTH-1]}}, b_i};
      fast_prod = fast_a * fast_b;
      fast_res  = (op_i[1:0] == 2'b00) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
   end
`endif

   muldiv_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (core_load),
      .step_i   (core_step),
      .div_i    (op_i[2]),
      .a_i      (a_mag),
      .b_i      (b_mag),
      .hi_nxt_o (hi_nxt),
      .lo_nxt_o (lo_nxt)
   );

   // Sign correction is taken from the final step so the result is ready on entry to DONE.
   always_comb begin
      prod_mag = {hi_nxt, lo_nxt};
      prod_fix = neg_res_q ? -prod_mag : prod_mag;
      quo_fix  = neg_res_q ? -lo_nxt : lo_nxt;
      rem_fix  = neg_res_q ? -hi_nxt : hi_nxt;
      unique case (op_q)
         OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              final_res = quo_fix;
         default:                      final_res = rem_fix;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_d           = op_q;
      neg_res_d      = neg_res_q;
      result_d       = result_q;
      core_load      = 1'b0;
      core_step      = 1'b0;
      stall_o        = 1'b0;
      busy_o         = 1'b0;
      result_valid_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            stall_o = accept;
            if (accept) begin
               op_d      = op_in;
               cnt_d     = '0;
               neg_res_d = res_neg;
               if (div_zero | div_ovf) begin
                  state_d  = ST_DONE;
                  result_d = early_res;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!op_i[2]) begin
                  state_d  = ST_DONE;
                  result_d = fast_res;
               end
`endif
               else begin
                  state_d   = ST_BUSY;
                  core_load = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            busy_o  = 1'b1;
            stall_o = ~flush_i;
            if (flush_i) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               core_step = 1'b1;
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d  = ST_DONE;
                  cnt_d    = '0;
                  result_d = final_res;
               end
            end
         end
         ST_DONE: begin
            result_valid_o = ~flush_i;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MUL;
         neg_res_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         neg_res_q <= neg_res_d;
         result_q  <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases, flush/reset aborts,
// then randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

   typedef struct {
      logic [31:0] res;
      int unsigned due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  op_i = 3'b000;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        stall_o, busy_o, result_valid_o;
   logic [31:0] result_o;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cycle_count = 0;
   int          checks = 0;
   int          errors = 0;

   logic [2:0]  dir_op[12]  = '{3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd1, 3'd3, 3'd2};
   logic [31:0] dir_a[12]   = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
   logic [31:0] dir_b[12]   = '{32'd6, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2};
   logic [31:0] dir_exp[12] = '{32'd42, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5,
                                32'h80000000, 32'd0, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   muldiv_sequencer #(
      .WIDTH (32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .op_i           (op_i),
      .a_i            (a_i),
      .b_i            (b_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] pa, pb, p;
      int          sa, sb_v;
      case (op)
         3'd0, 3'd1, 3'd2, 3'd3: begin
            pa = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
            pb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
            p  = pa * pb;
            return (op == 3'd0) ? p[31:0] : p[63:32];
         end
         3'd4, 3'd6: begin
            if (b == 32'd0) return (op == 3'd4) ? 32'hFFFFFFFF : a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return (op == 3'd4) ? a : 32'd0;
            sa   = a;
            sb_v = b;
            return (op == 3'd4) ? 32'(sa / sb_v) : 32'(sa % sb_v);
         end
         default: begin
            if (b == 32'd0) return (op == 3'd5) ? 32'hFFFFFFFF : a;
            return (op == 3'd5) ? (a / b) : (a % b);
         end
      endcase
   endfunction

   function automatic int unsigned refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 32'd0) return 1;
      if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[2]) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Called at posedge+1; start_i is held like a stalled pipeline until the result appears.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expected);
      int unsigned lat;
      bit          seen;
      lat     = refLatency(op, a, b);
      op_i    = op;
      a_i     = a;
      b_i     = b;
      start_i = 1'b1;
      sb.push_back('{res: expected, due: cycle_count + lat});
      #1 checkOutput("stall_on_start", 32'(stall_o), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("busy_after_start", 32'(busy_o), 32'(lat > 1));
      checkOutput("stall_after_start", 32'(stall_o), 32'(lat > 1));
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (result_valid_o === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout op=%0d actual=no_valid expected=valid", op);
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   always @(negedge clk) begin
      if (result_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid actual=%h expected=no_pulse", result_o);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("result", result_o, mon_e.res);
            checkOutput("latency", cycle_count, mon_e.due);
            checkOutput("stall_in_done", 32'(stall_o), 32'd0);
         end
      end
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_result", result_o, 32'd0);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      checkOutput("reset_stall", 32'(stall_o), 32'd0);
      checkOutput("reset_valid", 32'(result_valid_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) applyStimulus(dir_op[i], dir_a[i], dir_b[i], dir_exp[i]);

      // Flush a divide mid-flight, then start a new op on the following cycle.
      op_i    = 3'd4;
      a_i     = 32'd1000;
      b_i     = 32'd3;
      start_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1;
      #1;
      checkOutput("flush_stall", 32'(stall_o), 32'd0);
      checkOutput("flush_valid", 32'(result_valid_o), 32'd0);
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      start_i = 1'b0;
      checkOutput("flush_idle_busy", 32'(busy_o), 32'd0);
      checkOutput("flush_result_held", result_o, 32'hFFFFFFFF);
      applyStimulus(3'd5, 32'd100, 32'd7, 32'd14);

      // Reset mid-op clears every output on the next edge.
      op_i    = 3'd5;
      a_i     = 32'd999;
      b_i     = 32'd10;
      start_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst_n   = 1'b0;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midop_reset_result", result_o, 32'd0);
      checkOutput("midop_reset_busy", 32'(busy_o), 32'd0);
      checkOutput("midop_reset_stall", 32'(stall_o), 32'd0);
      checkOutput("midop_reset_valid", 32'(result_valid_o), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 50; n++) begin
         logic [2:0]  r_op;
         logic [31:0] r_a, r_b;
         r_op = 3'($urandom_range(0, 7));
         r_a  = pickOperand();
         r_b  = pickOperand();
         applyStimulus(r_op, r_a, r_b, refModel(r_op, r_a, r_b));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the RV32M multiply/divide execute path. It sits beside the single-cycle ALU in the EX stage and accepts an M-extension op selected by funct3. It sequences an iterative shift-add multiplier or a restoring divider, and drives the stall to the hazard unit until the result is ready.

Parameters:
WIDTH, 32, operand/result width in bits (iteration count = WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start_i  in  1  EX holds a valid M-extension instruction
op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  in  WIDTH  rs1 operand, forwarded
b_i  in  WIDTH  rs2 operand, forwarded
flush_i  in  1  EX flush (branch mispredict or redirect); aborts the op
stall_o  out  1  freezes PC/IF/ID/EX when high
busy_o  out  1  FSM in BUSY
result_valid_o  out  1  one-cycle pulse; result_o is valid
result_o  out  WIDTH  op result, held until the next accepted start

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low, sampled on the clk rising edge, and has priority over all other inputs.
- Reset values: state=IDLE, counter=0, all internal registers 0. stall_o=0, busy_o=0, result_valid_o=0, result_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start_i=1 and flush_i=0 at cycle T: latch op_i, a_i, b_i; counter=0; move to BUSY.
  - stall_o = start_i & ~flush_i, combinational in cycle T, so the pipeline holds the instruction.
- Operand preparation at latch:
  - Signed ops convert operands to magnitude and record the result signs.
  - MULHSU treats only a as signed.
  - Final negation is applied on entry to DONE.
- BUSY:
  - stall_o=1, busy_o=1.
  - One iteration per cycle; the counter increments each cycle.
  - At counter==WIDTH-1, move to DONE.
  - Normal result: result_valid_o=1 in cycle T+WIDTH+1 (T+33 for WIDTH=32).
- Early out: two cases go IDLE->DONE directly, with the result in T+1. No iteration happens.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = a.
  - Signed overflow (DIV/REM only, a = most-negative, b = -1): quotient = a, remainder = 0.
- DONE:
  - result_valid_o=1, stall_o=0, result_o updated.
  - start_i is ignored; it is still the same instruction in EX.
  - Move to IDLE unconditionally.
- Result selection:
  - MUL: low WIDTH bits of the 2*WIDTH product.
  - MULH/MULHSU/MULHU: high WIDTH bits of the product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder sign follows the dividend.
- Flush:
  - flush_i=1 in any state: IDLE next cycle, no result_valid_o, result_o unchanged, stall_o=0 in that cycle.
  - Flush beats start.
- Back-to-back ops: a new start is accepted in IDLE, the cycle after DONE.
- Non-M instructions: start_i stays low and the block stays IDLE, with stall_o=0.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiply ops (op_i[2]=0) use a single-cycle WIDTH x WIDTH multiplier. IDLE->DONE directly, result in T+1, no BUSY. Divides stay iterative.
- Undefined: all ops use the iterative path described above.

Decomposition:
- Package muldiv_pkg holds:
  - the muldiv_op_e enum of the eight funct3 codes
  - the muldiv_state_e enum (IDLE/BUSY/DONE)
  - the helper constant for the counter width, $clog2(WIDTH)
- Sub-module muldiv_core: registered accumulator/quotient/remainder with one shift-add or restore step per enable. It has no FSM.
- muldiv_sequencer owns the FSM, counter, sign handling, early-out detection and stall.

Test Plan:
1. MUL a=7, b=6, start at T -> stall_o high T..T+32, result_valid_o=1 at T+33, result_o=42, next cycle IDLE.
2. DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14; REMU -> 2.
3. DIVU a=5, b=0 -> result_o=0xFFFFFFFF at T+1. REM a=5, b=0 -> 5 at T+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
4. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
5. Abort and reset mid-op:
   - Flush: start DIV at T, flush_i=1 at T+10 -> state IDLE at T+11, no result_valid_o pulse, stall_o=0 at T+10. A start at T+11 is accepted normally.
   - Reset: rst_n=0 at T+5 -> all outputs 0 next cycle.
6. With MULDIV_FAST_MUL_EN: MUL 7*6 -> result_valid_o at T+1, result_o=42. DIVU 100/7 still at T+33.
